// File: rtl/mem_line_fetcher_pkg.sv
// Shared definitions for the instruction-cache line fetcher: line geometry,
// bus widths, the fetch FSM state encoding and address helpers.
package mem_line_fetcher_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int BENCH_WIDTH = 128;
    localparam int ADDR_WIDTH  = 32;
    localparam int CNT_WIDTH   = 4;

    // Clears the byte offset inside a 16-byte line.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = 32'hFFFF_FFF0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FILL = 2'b01,
        ST_DONE = 2'b10
    } fetch_state_e;

    // Line-aligned base of any byte address.
    function automatic logic [ADDR_WIDTH-1:0] line_base(input logic [ADDR_WIDTH-1:0] addr);
        return addr & LINE_MASK;
    endfunction

    // Byte address inside a line.  The offset is ORed into the cleared low
    // nibble, so it can never carry into the line index.
    function automatic logic [ADDR_WIDTH-1:0] byte_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [CNT_WIDTH-1:0]  idx);
        return base | {{(ADDR_WIDTH-CNT_WIDTH){1'b0}}, idx};
    endfunction

endpackage

// File: rtl/mem_line_fetcher.sv
// Instruction-cache line fetcher: on a fill request, reads the 16 bytes of
// the aligned line from a byte-wide RAM with one-cycle read latency and
// assembles them into a 128-bit line, then pulses done for one cycle.
//
// Optional build macro: MEM_FETCH_ABORT_EN -- when defined, dropping req
// during a fill abandons it (back to IDLE, no done, partial line kept).
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for req; RAM port quiet
// ST_FILL | 16 address cycles (ram_rd = 1) then one drain cycle
// ST_DONE | line complete, done pulses; always returns to IDLE
module mem_line_fetcher #(
    parameter int LINE_BYTES = 16
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         req,
    input  logic [31:0]  req_addr,
    output logic [127:0] line_o,
    output logic         done,
    output logic         busy,
    output logic         ram_rd,
    output logic [31:0]  ram_addr,
    input  logic [7:0]   ram_din
);
    import mem_line_fetcher_pkg::*;

    localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(LINE_BYTES - 1);

    fetch_state_e           r_state;
    fetch_state_e           w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_base;
    logic [CNT_WIDTH-1:0]   r_cnt;
    logic                   r_drain;
    logic                   r_cap_vld;
    logic [CNT_WIDTH-1:0]   r_cap_lane;
    logic [BENCH_WIDTH-1:0] r_line;
    logic                   w_abort;
    logic                   w_start;
    logic                   w_fill_step;

`ifdef MEM_FETCH_ABORT_EN
    assign w_abort = (r_state == ST_FILL) && !req;
`else
    assign w_abort = 1'b0;
`endif

    assign w_start     = (r_state == ST_IDLE) && req;
    assign w_fill_step = (r_state == ST_FILL) && !r_drain && !w_abort;

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        done        = 1'b0;
        busy        = 1'b0;
        ram_rd      = 1'b0;
        ram_addr    = '0;
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                busy = 1'b1;
                if (!r_drain) begin
                    ram_rd   = 1'b1;
                    ram_addr = byte_addr(r_base, r_cnt);
                end
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_drain) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Latch the line base on a new request and walk the byte counter;
    // r_drain marks the extra cycle that waits for the last byte.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_base  <= '0;
            r_cnt   <= '0;
            r_drain <= 1'b0;
        end else begin
            if (w_start) begin
                r_base  <= line_base(req_addr);
                r_cnt   <= '0;
                r_drain <= 1'b0;
            end else if (w_fill_step) begin
                r_cnt <= r_cnt + CNT_WIDTH'(1);
                if (r_cnt == LAST_IDX) begin
                    r_drain <= 1'b1;
                end
            end else if (w_state_nxt != ST_FILL) begin
                r_drain <= 1'b0;
            end
        end
    end

    // Track which lane the returning RAM byte belongs to.  A read issued in
    // the cycle of an abort is dropped so it cannot land after the abort.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cap_vld  <= 1'b0;
            r_cap_lane <= '0;
        end else begin
            r_cap_vld  <= ram_rd && !w_abort;
            r_cap_lane <= r_cnt;
        end
    end

    // Write the returning byte into its lane; other lanes hold.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_line <= '0;
        end else if (r_cap_vld) begin
            r_line[{r_cap_lane, 3'b000} +: 8] <= ram_din;
        end
    end

    assign line_o = r_line;

endmodule

// File: tb/tb_mem_line_fetcher.sv
// Self-checking bench for mem_line_fetcher.  Cycle k = 0 is the first FILL
// cycle after the edge that sampled req; a fill is 17 FILL cycles (k=0..16),
// DONE at k=17, IDLE at k=18.
module tb_mem_line_fetcher;

    logic         CLK = 1'b0;
    logic         RST;
    logic         req;
    logic [31:0]  req_addr;
    logic [127:0] line_o;
    logic         done;
    logic         busy;
    logic         ram_rd;
    logic [31:0]  ram_addr;
    logic [7:0]   ram_din;

    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    int           last_done_cyc = 0;
    logic [7:0]   seed = 8'h00;
    logic         mix = 1'b0;
    logic [127:0] model_line = '0;

    mem_line_fetcher #(.LINE_BYTES(16)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .req      (req),
        .req_addr (req_addr),
        .line_o   (line_o),
        .done     (done),
        .busy     (busy),
        .ram_rd   (ram_rd),
        .ram_addr (ram_addr),
        .ram_din  (ram_din)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Contents of the byte RAM.
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        return a[7:0] ^ seed ^ (mix ? a[15:8] : 8'h00);
    endfunction

    // Byte RAM with one-cycle read latency; garbage when not read.
    always @(posedge CLK) begin
        if (ram_rd) ram_din <= mem_byte(ram_addr);
        else        ram_din <= 8'($urandom);
    end

    // One complete fill from an idle start (entered mid-cycle), checked
    // cycle by cycle against the expected RAM walk and the expected line.
    task automatic run_fill(input logic [31:0] addr, input int chg_cycle,
                            input logic [31:0] chg_addr, input int drop_cycle,
                            input bit keep_req);
        logic [31:0]  base;
        logic [127:0] exp_line;
        logic [31:0]  exp_addr;
        base = {addr[31:4], 4'h0};
        for (int j = 0; j < 16; j++) exp_line[8*j +: 8] = mem_byte(base + 32'(j));
        req      = 1'b1;
        req_addr = addr;
        @(posedge CLK);
        for (int k = 0; k <= 18; k++) begin
            if (k > 0) @(posedge CLK);
            #1;
            total++;
            if (busy !== (k <= 17)) begin
                bad++;
                $display("FAIL busy k=%0d got=%b want=%b", k, busy, (k <= 17));
            end
            total++;
            if (done !== (k == 17)) begin
                bad++;
                $display("FAIL done k=%0d got=%b want=%b", k, done, (k == 17));
            end
            total++;
            if (ram_rd !== (k < 16)) begin
                bad++;
                $display("FAIL ram_rd k=%0d got=%b want=%b", k, ram_rd, (k < 16));
            end
            if (k < 16 || k == 18) begin
                exp_addr = (k < 16) ? base + 32'(k) : 32'h0;
                total++;
                if (ram_addr !== exp_addr) begin
                    bad++;
                    $display("FAIL ram_addr k=%0d got=%h want=%h", k, ram_addr, exp_addr);
                end
            end
            if (k == 17) begin
                if (done === 1'b1) last_done_cyc = cyc;
                total++;
                if (line_o !== exp_line) begin
                    bad++;
                    $display("FAIL line base=%h got=%h want=%h", base, line_o, exp_line);
                end
                model_line = exp_line;
            end
            @(negedge CLK);
            if (k == chg_cycle) req_addr = chg_addr;
            if (k == drop_cycle) req = 1'b0;
            if (k == 17 && !keep_req) req = 1'b0;
        end
    endtask

    task automatic test_reset;
        RST = 1'b0; req = 1'b0; req_addr = 32'h0;
        #1;
        total++;
        if ({line_o, done, busy, ram_rd, ram_addr} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%h/%b%b%b/%h want=0", line_o, done, busy, ram_rd, ram_addr);
        end
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({done, busy, ram_rd} !== 3'b000) begin
            bad++;
            $display("FAIL reset_held got=%b want=000", {done, busy, ram_rd});
        end
        @(negedge CLK);
        RST = 1'b1;
        // first edge after release must already sample req
        seed = 8'h5A; mix = 1'b1;
        run_fill(32'h0000_4444, -1, 0, -1, 0);
    endtask

    task automatic test_spec_line;
        seed = 8'h00; mix = 1'b0;
        run_fill(32'h0000_1238, -1, 0, -1, 0);
        repeat (3) @(negedge CLK);
        total++;
        if (line_o !== 128'h3F3E3D3C3B3A39383736353433323130) begin
            bad++;
            $display("FAIL spec_line_hold got=%h want=3f3e..3130", line_o);
        end
    endtask

    task automatic test_random;
        for (int n = 0; n < 8; n++) begin
            seed = 8'($urandom); mix = 1'b1;
            run_fill($urandom, -1, 0, -1, 0);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
    endtask

    task automatic test_back_to_back;
        int d1, d2, d3;
        seed = 8'($urandom); mix = 1'b1;
        run_fill($urandom, -1, 0, -1, 1);
        d1 = last_done_cyc;
        run_fill($urandom, -1, 0, -1, 1);
        d2 = last_done_cyc;
        run_fill($urandom, -1, 0, -1, 0);
        d3 = last_done_cyc;
        total++;
        if (d2 - d1 != 19) begin
            bad++;
            $display("FAIL b2b_spacing1 got=%0d want=19", d2 - d1);
        end
        total++;
        if (d3 - d2 != 19) begin
            bad++;
            $display("FAIL b2b_spacing2 got=%0d want=19", d3 - d2);
        end
    endtask

    task automatic test_addr_change;
        seed = 8'($urandom); mix = 1'b1;
        run_fill(32'h0001_7A5C, 5, 32'h0000_2000, -1, 0);
    endtask

    task automatic test_wrap;
        seed = 8'($urandom); mix = 1'b1;
        run_fill(32'hFFFF_FFF0, -1, 0, -1, 0);
        run_fill(32'hFFFF_FFFB, -1, 0, -1, 0);
    endtask

    task automatic test_reset_mid_fill;
        seed = 8'($urandom); mix = 1'b1;
        req = 1'b1; req_addr = $urandom;
        @(posedge CLK);
        repeat (9) @(posedge CLK);
        #1;
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_busy_before got=%b want=1", busy);
        end
        @(negedge CLK);
        RST = 1'b0; req = 1'b0;
        #1;
        total++;
        if ({line_o, done, busy, ram_rd, ram_addr} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%h/%b%b%b/%h want=0", line_o, done, busy, ram_rd, ram_addr);
        end
        model_line = '0;
        @(negedge CLK);
        RST = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(posedge CLK); #1;
            total++;
            if ({done, busy} !== 2'b00) begin
                bad++;
                $display("FAIL rst_mid_quiet k=%0d got=%b want=00", k, {done, busy});
            end
        end
        @(negedge CLK);
        run_fill($urandom, -1, 0, -1, 0);
    endtask

    task automatic test_req_drop;
`ifdef MEM_FETCH_ABORT_EN
        logic [127:0] old_line, exp_line, mask;
        logic [31:0]  base, a;
        int           seen_done;
        seed = 8'($urandom); mix = 1'b1;
        a = $urandom;
        base = {a[31:4], 4'h0};
        old_line = model_line;
        exp_line = old_line;
        for (int j = 0; j < 3; j++) exp_line[8*j +: 8] = mem_byte(base + 32'(j));
        mask = ~(128'hFF << 24);
        req = 1'b1; req_addr = a;
        @(posedge CLK);
        for (int k = 0; k <= 3; k++) begin
            if (k > 0) @(posedge CLK);
            #1;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL abort_busy k=%0d got=%b want=1", k, busy);
            end
            @(negedge CLK);
            if (k == 3) req = 1'b0;
        end
        @(posedge CLK); #1;
        total++;
        if ({busy, done, ram_rd} !== 3'b000) begin
            bad++;
            $display("FAIL abort_idle got=%b want=000", {busy, done, ram_rd});
        end
        seen_done = 0;
        repeat (20) begin
            @(posedge CLK); #1;
            if (done === 1'b1) seen_done++;
        end
        total++;
        if (seen_done != 0) begin
            bad++;
            $display("FAIL abort_no_done got=%0d want=0", seen_done);
        end
        total++;
        if ((line_o & mask) !== (exp_line & mask)) begin
            bad++;
            $display("FAIL abort_partial_line got=%h want=%h", line_o & mask, exp_line & mask);
        end
        @(negedge CLK);
        run_fill($urandom, -1, 0, -1, 0);
`else
        seed = 8'($urandom); mix = 1'b1;
        run_fill($urandom, -1, 0, 3, 0);
        run_fill($urandom, -1, 0, int'($urandom_range(0, 15)), 0);
`endif
    endtask

    initial begin
        test_reset();
        test_spec_line();
        test_random();
        test_back_to_back();
        test_addr_change();
        test_wrap();
        test_reset_mid_fill();
        test_req_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_line_fetcher.md
MEM_LINE_FETCHER -- requirements
Module: mem_line_fetcher

Interface
REQ-001 SHALL have parameter LINE_BYTES, default 16, bytes per cache line; only 16 is supported.
REQ-002 SHALL have port CLK  input  1  the single rising-edge clock.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  1  line-fill request from the instruction cache (its mem_read).
REQ-005 SHALL have port req_addr  input  32  fill address from the instruction cache.
REQ-006 SHALL have port line_o  output  128  assembled line; byte k at bits [8k+7:8k].
REQ-007 SHALL have port done  output  1  one-cycle pulse; line_o is valid in that cycle.
REQ-008 SHALL have port busy  output  1  a fill is in progress.
REQ-009 SHALL have port ram_rd  output  1  byte-RAM read strobe.
REQ-010 SHALL have port ram_addr  output  32  byte-RAM address.
REQ-011 SHALL have port ram_din  input  8  byte-RAM read data, valid the cycle after ram_addr/ram_rd are presented.

Function
REQ-012 SHALL implement states IDLE, FILL and DONE.
REQ-013 In IDLE, with req sampled high at a rising edge, SHALL latch base = {req_addr[31:4], 4'b0000} and enter FILL.
REQ-014 In FILL cycle i (i = 0..15), SHALL drive ram_rd = 1 and ram_addr = base + i.
REQ-015 SHALL capture ram_din into line_o byte lane i at the end of cycle i+1.
REQ-016 Therefore SHALL run FILL for 17 cycles: 16 address cycles plus 1 drain cycle with ram_rd = 0.
REQ-017 SHALL enter DONE after the byte-15 capture and assert done for exactly one cycle, 18 cycles after the sampling edge.
REQ-018 SHALL return from DONE to IDLE unconditionally; req is not sampled in DONE.
REQ-019 In IDLE, SHALL drive ram_rd = 0 and ram_addr = 0.
REQ-020 SHALL drive busy = 1 in FILL and DONE and busy = 0 in IDLE.
REQ-021 SHALL ignore req_addr changes during FILL and use only the latched base.
REQ-022 SHALL hold line_o from the last completed fill until the next fill overwrites it byte by byte.
REQ-023 SHALL compute the byte counter in 4 bits; base + i SHALL never carry out of bits [3:0].
REQ-024 A req arriving in the same cycle as done SHALL start a new fill only if req is still high in the following IDLE cycle.
REQ-025 In steady state, back-to-back fills SHALL be separated by exactly one IDLE cycle.

Reset
REQ-026 With RST low, SHALL go to IDLE immediately (asynchronously) and drive line_o = 0, done = 0, busy = 0, ram_rd = 0, ram_addr = 0.
REQ-027 Reset during FILL or DONE SHALL discard the partial line, produce no done pulse, and discard in-flight RAM data.
REQ-028 After RST deasserts, SHALL sample req on the first rising edge.

Configuration
REQ-029 With macro MEM_FETCH_ABORT_EN defined, req sampled low during FILL SHALL return the block to IDLE on the next cycle, with no done pulse and busy = 0 from that cycle; line_o keeps its partially written bytes.
REQ-030 Without MEM_FETCH_ABORT_EN, req SHALL be ignored during FILL and every started fill SHALL complete with done.

Structure
REQ-031 The shared defines.v SHALL hold LINE_BYTES, BENCH_WIDTH (128), ADDR_WIDTH and the three state encodings; the instruction cache uses the same BENCH_WIDTH.
REQ-032 SHALL contain no sub-module; the byte-lane write and the counter are implemented inline.

Verification
REQ-033 Scenario: RAM holds byte value = address[7:0]; req = 1, req_addr = 0x0000_1238 -> ram_addr 0x1230..0x123F in consecutive cycles; done 18 cycles later; line_o = 0x3F3E...3130.
REQ-034 Scenario: req held high continuously -> done pulses spaced 19 cycles apart; busy low for exactly one cycle between fills.
REQ-035 Scenario: req_addr changed to 0x2000 in FILL cycle 5 -> ram_addr continues from base + 6; line_o reflects the original line only.
REQ-036 Scenario: RST pulsed low in FILL cycle 9 -> all outputs 0 immediately; no done; next req completes a normal 18-cycle fill.
REQ-037 Scenario (MEM_FETCH_ABORT_EN defined): req drops in FILL cycle 3 -> IDLE next cycle, busy = 0, no done; without the macro, done still fires at cycle 18.
REQ-038 Scenario: req_addr = 0xFFFF_FFF0 -> ram_addr 0xFFFF_FFF0..0xFFFF_FFFF with no wrap into the next line; done at cycle 18.
